csr_commit_file: RTL and testbench



---
 rtl/csr_commit_file_pkg.sv | 47 ++++
 rtl/csr_commit_file_if.sv | 36 +++
 rtl/csr_commit_file_counter64.sv | 31 +++
 rtl/csr_commit_file.sv | 127 ++++++++++++
 tb/tb_csr_commit_file.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/csr_commit_file_pkg.sv
// rtl/csr_commit_file_pkg.sv - shared widths, CSR addresses and pending-entry type
package csr_commit_file_pkg;

  localparam int CSR_WIDTH    = 64;
  localparam int CSR_ADDR_W   = 12;
  localparam int TAG_W        = 7;
  localparam int COMMIT_WIDTH = 4;
  localparam int CNT_W        = $clog2(COMMIT_WIDTH + 1);

  localparam logic [CSR_ADDR_W-1:0] CSR_FFLAGS   = 12'h001;
  localparam logic [CSR_ADDR_W-1:0] CSR_FRM      = 12'h002;
  localparam logic [CSR_ADDR_W-1:0] CSR_FCSR     = 12'h003;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE    = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_TIME     = 12'hC01;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET  = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH = 12'h340;

  // Bit positions inside fflags
  typedef enum logic [2:0] {
    FFLAG_NX = 3'd0,
    FFLAG_UF = 3'd1,
    FFLAG_OF = 3'd2,
    FFLAG_DZ = 3'd3,
    FFLAG_NV = 3'd4
  } fflag_bit_e;

  typedef enum logic {
    PB_EMPTY   = 1'b0,
    PB_PENDING = 1'b1
  } pb_state_e;

  typedef struct packed {
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_WIDTH-1:0]  data;
    logic [TAG_W-1:0]      tag;
  } pending_t;

  function automatic logic csr_is_legal(input logic [CSR_ADDR_W-1:0] addr);
    case (addr)
      CSR_FFLAGS, CSR_FRM, CSR_FCSR,
      CSR_CYCLE, CSR_TIME, CSR_INSTRET,
      CSR_MSCRATCH: csr_is_legal = 1'b1;
      default:      csr_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_commit_file_if.sv
// rtl/csr_commit_file_if.sv - write/commit/read bundle between pipeline and CSR file
interface csr_commit_file_if;
  import csr_commit_file_pkg::*;

  logic                  csrWrEn_i;
  logic [CSR_ADDR_W-1:0] csrWrAddr_i;
  logic [CSR_WIDTH-1:0]  csrWrData_i;
  logic [TAG_W-1:0]      csrWrTag_i;
  logic                  commitCsr_i;
  logic [TAG_W-1:0]      commitCsrTag_i;
  logic                  recoverFlag_i;
  logic [CNT_W-1:0]      commitCount_i;
  logic                  fpExcptValid_i;
  logic [4:0]            fpExcpt_i;
  logic [CSR_ADDR_W-1:0] csrRdAddr_i;
  logic [CSR_WIDTH-1:0]  csrRdData_o;
  logic                  csrRdLegal_o;
  logic                  csrBusy_o;
  logic                  csrCommitted_o;
  logic [2:0]            frm_o;

  modport master (
    output csrWrEn_i, csrWrAddr_i, csrWrData_i, csrWrTag_i,
    output commitCsr_i, commitCsrTag_i, recoverFlag_i, commitCount_i,
    output fpExcptValid_i, fpExcpt_i, csrRdAddr_i,
    input  csrRdData_o, csrRdLegal_o, csrBusy_o, csrCommitted_o, frm_o
  );

  modport slave (
    input  csrWrEn_i, csrWrAddr_i, csrWrData_i, csrWrTag_i,
    input  commitCsr_i, commitCsrTag_i, recoverFlag_i, commitCount_i,
    input  fpExcptValid_i, fpExcpt_i, csrRdAddr_i,
    output csrRdData_o, csrRdLegal_o, csrBusy_o, csrCommitted_o, frm_o
  );

endinterface

// File: rtl/csr_commit_file_counter64.sv
// rtl/csr_commit_file_counter64.sv - 64-bit wrapping counter with overriding load
module csr_counter64 #(
  parameter int W     = 64,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [INC_W-1:0] inc_i,
  input  logic             load_i,
  input  logic [W-1:0]     load_val_i,
  output logic [W-1:0]     count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A load replaces this cycle's increment entirely
  always_comb begin
    count_d = count_q + W'(inc_i);
    if (load_i) count_d = load_val_i;
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_commit_file.sv
// rtl/csr_commit_file.sv - architectural CSRs with single-entry commit-time write buffer
module csr_commit_file
  import csr_commit_file_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  csr_commit_file_if.slave   bus
);

  pb_state_e            state_q, state_d;
  pending_t             pend_q, pend_d;
  logic                 committed_q, committed_d;
  logic [2:0]           frm_q, frm_d;
  logic [4:0]           fflags_q, fflags_d;
  logic [CSR_WIDTH-1:0] mscratch_q, mscratch_d;

  logic                 commit_hit;
  logic                 ld_cycle, ld_instret;
  logic [CSR_WIDTH-1:0] cycle_val, instret_val;
  logic [4:0]           fp_acc;

  // Commit only applies to the write it owns; stale or foreign tags are ignored
  assign commit_hit = (state_q == PB_PENDING) && bus.commitCsr_i &&
                      (bus.commitCsrTag_i == pend_q.tag);

  // Pending buffer next state: commit beats recover, writes while PENDING are dropped
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      PB_EMPTY: begin
        if (bus.csrWrEn_i) begin
          state_d     = PB_PENDING;
          pend_d.addr = bus.csrWrAddr_i;
          pend_d.data = bus.csrWrData_i;
          pend_d.tag  = bus.csrWrTag_i;
        end
      end
      PB_PENDING: begin
        if (commit_hit || bus.recoverFlag_i) state_d = PB_EMPTY;
      end
      default: state_d = PB_EMPTY;
    endcase
  end

  // Architectural update: apply narrowed commit data, merge FP flag accrual
  always_comb begin
    committed_d = commit_hit;
    frm_d       = frm_q;
    mscratch_d  = mscratch_q;
    fp_acc      = bus.fpExcptValid_i ? bus.fpExcpt_i : 5'd0;
    fflags_d    = fflags_q | fp_acc;
    ld_cycle    = 1'b0;
    ld_instret  = 1'b0;
    if (commit_hit) begin
      case (pend_q.addr)
        CSR_FFLAGS:          fflags_d = pend_q.data[4:0] | fp_acc;
        CSR_FRM:             frm_d = pend_q.data[2:0];
        CSR_FCSR: begin
          frm_d    = pend_q.data[7:5];
          fflags_d = pend_q.data[4:0] | fp_acc;
        end
        CSR_CYCLE, CSR_TIME: ld_cycle = 1'b1;
        CSR_INSTRET:         ld_instret = 1'b1;
        CSR_MSCRATCH:        mscratch_d = pend_q.data;
        default: ;
      endcase
    end
  end

  // State and architectural registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PB_EMPTY;
      pend_q      <= '0;
      committed_q <= 1'b0;
      frm_q       <= 3'd0;
      fflags_q    <= 5'd0;
      mscratch_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      committed_q <= committed_d;
      frm_q       <= frm_d;
      fflags_q    <= fflags_d;
      mscratch_q  <= mscratch_d;
    end
  end

  csr_counter64 #(.W(CSR_WIDTH), .INC_W(1)) u_cycle (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (1'b1),
    .load_i     (ld_cycle),
    .load_val_i (pend_q.data),
    .count_o    (cycle_val)
  );

  csr_counter64 #(.W(CSR_WIDTH), .INC_W(CNT_W)) u_instret (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (bus.commitCount_i),
    .load_i     (ld_instret),
    .load_val_i (pend_q.data),
    .count_o    (instret_val)
  );

  // Combinational read of architectural state only; pending data is never forwarded
  always_comb begin
    bus.csrRdData_o  = '0;
    bus.csrRdLegal_o = csr_is_legal(bus.csrRdAddr_i);
    case (bus.csrRdAddr_i)
      CSR_FFLAGS:          bus.csrRdData_o = {{(CSR_WIDTH-5){1'b0}}, fflags_q};
      CSR_FRM:             bus.csrRdData_o = {{(CSR_WIDTH-3){1'b0}}, frm_q};
      CSR_FCSR:            bus.csrRdData_o = {{(CSR_WIDTH-8){1'b0}}, frm_q, fflags_q};
      CSR_CYCLE, CSR_TIME: bus.csrRdData_o = cycle_val;
      CSR_INSTRET:         bus.csrRdData_o = instret_val;
      CSR_MSCRATCH:        bus.csrRdData_o = mscratch_q;
      default:             bus.csrRdData_o = '0;
    endcase
  end

  assign bus.csrBusy_o      = (state_q == PB_PENDING);
  assign bus.csrCommitted_o = committed_q;
  assign bus.frm_o          = frm_q;

endmodule

// File: tb/tb_csr_commit_file.sv
// tb/tb_csr_commit_file.sv - directed self-checking bench for csr_commit_file
module tb_csr_commit_file;
  import csr_commit_file_pkg::*;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  csr_commit_file_if bus ();

  csr_commit_file dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    bus.csrRdAddr_i = addr;
    #1;
    chk(tag, bus.csrRdData_o, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [63:0] data, input logic [6:0] tag);
    bus.csrWrEn_i   = 1'b1;
    bus.csrWrAddr_i = addr;
    bus.csrWrData_i = data;
    bus.csrWrTag_i  = tag;
  endtask

  task automatic commit(input logic en, input logic [6:0] tag);
    bus.commitCsr_i    = en;
    bus.commitCsrTag_i = tag;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.csrWrEn_i = 1'b0;
    bus.csrWrAddr_i = '0;
    bus.csrWrData_i = '0;
    bus.csrWrTag_i = '0;
    bus.commitCsr_i = 1'b0;
    bus.commitCsrTag_i = '0;
    bus.recoverFlag_i = 1'b0;
    bus.commitCount_i = '0;
    bus.fpExcptValid_i = 1'b0;
    bus.fpExcpt_i = '0;
    bus.csrRdAddr_i = '0;

    // reset state
    repeat (3) tick();
    chk("rst_busy", 64'(bus.csrBusy_o), 64'd0);
    chk("rst_committed", 64'(bus.csrCommitted_o), 64'd0);
    chk("rst_frm_o", 64'(bus.frm_o), 64'd0);
    rd("rst_cycle", CSR_CYCLE, 64'd0);
    rd("rst_instret", CSR_INSTRET, 64'd0);
    reset_n = 1'b1;

    // idle 10 cycles
    repeat (10) tick();
    rd("idle_cycle", CSR_CYCLE, 64'd10);
    rd("idle_time", CSR_TIME, 64'd10);
    rd("idle_instret", CSR_INSTRET, 64'd0);
    chk("idle_busy", 64'(bus.csrBusy_o), 64'd0);
    rd("illegal_data", 12'h123, 64'd0);
    chk("illegal_legal", 64'(bus.csrRdLegal_o), 64'd0);
    rd("mscratch_rst", CSR_MSCRATCH, 64'd0);
    chk("mscratch_legal", 64'(bus.csrRdLegal_o), 64'd1);

    // mscratch write, mismatched commit, then matching commit
    wr(CSR_MSCRATCH, 64'hDEAD, 7'd5);
    tick();
    bus.csrWrEn_i = 1'b0;
    chk("ms_busy", 64'(bus.csrBusy_o), 64'd1);
    rd("ms_pre", CSR_MSCRATCH, 64'd0);
    commit(1'b1, 7'd6);
    tick();
    chk("ms_badtag_busy", 64'(bus.csrBusy_o), 64'd1);
    chk("ms_badtag_comm", 64'(bus.csrCommitted_o), 64'd0);
    commit(1'b1, 7'd5);
    rd("ms_pre2", CSR_MSCRATCH, 64'd0);
    tick();
    commit(1'b0, 7'd0);
    chk("ms_comm_pulse", 64'(bus.csrCommitted_o), 64'd1);
    chk("ms_busy_clr", 64'(bus.csrBusy_o), 64'd0);
    rd("ms_post", CSR_MSCRATCH, 64'hDEAD);
    tick();
    chk("ms_comm_end", 64'(bus.csrCommitted_o), 64'd0);

    // frm write discarded by recover; late commit has no effect
    wr(CSR_FRM, 64'd3, 7'd2);
    tick();
    bus.csrWrEn_i = 1'b0;
    chk("rc_busy", 64'(bus.csrBusy_o), 64'd1);
    bus.recoverFlag_i = 1'b1;
    tick();
    bus.recoverFlag_i = 1'b0;
    chk("rc_busy_clr", 64'(bus.csrBusy_o), 64'd0);
    chk("rc_frm_o", 64'(bus.frm_o), 64'd0);
    commit(1'b1, 7'd2);
    tick();
    commit(1'b0, 7'd0);
    chk("rc_late_comm", 64'(bus.csrCommitted_o), 64'd0);
    rd("rc_frm", CSR_FRM, 64'd0);

    // fcsr write with same-cycle FP flags; upper bits dropped
    wr(CSR_FCSR, 64'hFFE1, 7'd1);
    tick();
    bus.csrWrEn_i = 1'b0;
    commit(1'b1, 7'd1);
    bus.fpExcptValid_i = 1'b1;
    bus.fpExcpt_i = 5'h04;
    tick();
    commit(1'b0, 7'd0);
    bus.fpExcptValid_i = 1'b0;
    bus.fpExcpt_i = 5'h00;
    rd("fc_frm", CSR_FRM, 64'd7);
    rd("fc_fflags", CSR_FFLAGS, 64'h05);
    rd("fc_fcsr", CSR_FCSR, 64'hE5);
    chk("fc_frm_o", 64'(bus.frm_o), 64'd7);
    bus.fpExcptValid_i = 1'b1;
    bus.fpExcpt_i = 5'h10;
    tick();
    bus.fpExcptValid_i = 1'b0;
    bus.fpExcpt_i = 5'h00;
    rd("fc_accrue", CSR_FFLAGS, 64'h15);

    // instret accumulation then committed load overriding the increment
    wr(CSR_INSTRET, 64'd100, 7'd9);
    bus.commitCount_i = 3'd4;
    tick();
    bus.csrWrEn_i = 1'b0;
    tick();
    tick();
    rd("ir_12", CSR_INSTRET, 64'd12);
    commit(1'b1, 7'd9);
    bus.commitCount_i = 3'd2;
    tick();
    commit(1'b0, 7'd0);
    rd("ir_100", CSR_INSTRET, 64'd100);
    bus.commitCount_i = 3'd3;
    tick();
    bus.commitCount_i = 3'd0;
    rd("ir_103", CSR_INSTRET, 64'd103);

    // cycle=0 write, ignored second write, commit+recover same cycle
    wr(CSR_CYCLE, 64'd0, 7'd3);
    tick();
    wr(CSR_MSCRATCH, 64'h1234, 7'd4);
    tick();
    bus.csrWrEn_i = 1'b0;
    chk("cy_busy", 64'(bus.csrBusy_o), 64'd1);
    commit(1'b1, 7'd4);
    tick();
    chk("cy_tag4_comm", 64'(bus.csrCommitted_o), 64'd0);
    chk("cy_tag4_busy", 64'(bus.csrBusy_o), 64'd1);
    commit(1'b1, 7'd3);
    bus.recoverFlag_i = 1'b1;
    tick();
    commit(1'b0, 7'd0);
    bus.recoverFlag_i = 1'b0;
    chk("cy_comm", 64'(bus.csrCommitted_o), 64'd1);
    chk("cy_busy_clr", 64'(bus.csrBusy_o), 64'd0);
    rd("cy_0", CSR_CYCLE, 64'd0);
    rd("cy_ms_kept", CSR_MSCRATCH, 64'hDEAD);
    wr(CSR_MSCRATCH, 64'h55, 7'd8);
    tick();
    bus.csrWrEn_i = 1'b0;
    rd("cy_1", CSR_CYCLE, 64'd1);
    chk("bb_busy", 64'(bus.csrBusy_o), 64'd1);
    commit(1'b1, 7'd8);
    tick();
    commit(1'b0, 7'd0);
    rd("bb_ms", CSR_MSCRATCH, 64'h55);

    // reset while pending discards the write
    wr(CSR_MSCRATCH, 64'h77, 7'd10);
    tick();
    bus.csrWrEn_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rp_busy", 64'(bus.csrBusy_o), 64'd0);
    rd("rp_ms", CSR_MSCRATCH, 64'd0);
    rd("rp_fflags", CSR_FFLAGS, 64'd0);
    tick();
    reset_n = 1'b1;
    commit(1'b1, 7'd10);
    tick();
    commit(1'b0, 7'd0);
    chk("rp_comm", 64'(bus.csrCommitted_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
